// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between the MEM stage and the data memory controller
// Master is the pipeline requester, slave is the memory controller.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic                  done;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, done, rdata, err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - clocked data memory with wait states, byte enables and range/alignment checking
// One access in flight; the array and the response registers update on the edge entering DONE.
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  data_memory_ctrl_if.slave s_bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    r_be;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ready, w_done, w_enter_done, w_bad, w_cur_we;
  logic [ADDR_W-1:0]   w_cur_addr, w_word_idx;
  logic [DATA_W-1:0]   w_cur_wdata;
  logic [BYTES-1:0]    w_cur_be;

  // With zero wait states DONE is entered straight from IDLE, before capture lands.
  assign w_cur_we    = (r_state == S_IDLE) ? s_bus.we    : r_we;
  assign w_cur_addr  = (r_state == S_IDLE) ? s_bus.addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? s_bus.wdata : r_wdata;
  assign w_cur_be    = (r_state == S_IDLE) ? s_bus.be    : r_be;

  assign w_word_idx   = w_cur_addr >> OFF_W;
  assign w_bad        = ((w_cur_addr & ADDR_W'(BYTES - 1)) != '0) ||
                        (w_word_idx >= ADDR_W'(DEPTH));
  assign w_enter_done = (r_state != S_DONE) && (w_next == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (s_bus.req) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_DONE:  w_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && s_bus.req) begin
        r_we    <= s_bus.we;
        r_addr  <= s_bus.addr;
        r_wdata <= s_bus.wdata;
        r_be    <= s_bus.be;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_done) begin
        if (w_bad) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          r_rdata <= w_cur_we ? '0 : r_mem[w_word_idx[IDX_W-1:0]];
          r_err   <= 1'b0;
        end
      end
    end
  end

  // Array is not reset; reset gating keeps an aborted write out of it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_enter_done && w_cur_we && !w_bad) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_cur_be[i]) r_mem[w_word_idx[IDX_W-1:0]][i*8 +: 8] <= w_cur_wdata[i*8 +: 8];
      end
    end
  end

  assign s_bus.ready = w_ready;
  assign s_bus.done  = w_done;
  assign s_bus.rdata = r_rdata;
  assign s_bus.err   = r_err;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
// Main instance uses two wait states; a second instance covers the zero-wait case.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32)) mif ();
  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(32)) m0 ();

  data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(2)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_bus   (mif.slave)
  );

  data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_bus   (m0.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one access on the main instance; with hold set, req stays high with different inputs during the wait.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("ready_before_req", 32'(mif.ready), 32'd1);
    mif.req = 1'b1; mif.we = we; mif.addr = addr; mif.wdata = wdata; mif.be = be;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      mif.addr = 32'h16; mif.we = ~we; mif.wdata = 32'hFFFF_FFFF; mif.be = 4'hF;
    end else begin
      mif.req = 1'b0;
    end
    lat = 0;
    while (!mif.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ready_low_in_done", 32'(mif.ready), 32'd0);
    rd = mif.rdata;
    er = mif.err;
    mif.req = 1'b0;
    @(negedge clk);
    check("ready_back", 32'(mif.ready), 32'd1);
    check("done_dropped", 32'(mif.done), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    mif.req = 0; mif.we = 0; mif.addr = 0; mif.wdata = 0; mif.be = 0;
    m0.req  = 0; m0.we  = 0; m0.addr  = 0; m0.wdata  = 0; m0.be  = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(mif.ready), 32'd1);
    check("rst_done",  32'(mif.done),  32'd0);
    check("rst_rdata", mif.rdata,      32'd0);
    check("rst_err",   32'(mif.err),   32'd0);

    access(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_err",     32'(er),  32'd0);
    check("wr_rdata",   rd,       32'd0);
    access(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("rd_latency", 32'(lat), 32'd2);
    check("rd_data",    rd,       32'hDEAD_BEEF);
    check("rd_err",     32'(er),  32'd0);

    access(1'b1, 32'h14, 32'h1122_3344, 4'b0101, 1'b0, rd, er, lat);
    access(1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("be_merge", rd, 32'hDE22_BE44);

    access(1'b0, 32'h16, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("misalign_err",   32'(er), 32'd1);
    check("misalign_rdata", rd,      32'd0);
    check("err_held_idle",  32'(mif.err), 32'd1);

    access(1'b1, 32'h0, 32'h1234_5678, 4'hF, 1'b0, rd, er, lat);
    access(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    access(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("oor_word0_kept", rd, 32'h1234_5678);
    check("rd_err_clear",   32'(er), 32'd0);

    access(1'b1, 32'h14, 32'hAAAA_AAAA, 4'h0, 1'b0, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    access(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, rd, er, lat);
    check("hold_rd_data", rd, 32'hDE22_BE44);
    check("hold_rd_err",  32'(er), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_no_extra_done", 32'(mif.done), 32'd0);
    end

    access(1'b1, 32'h08, 32'h0000_0007, 4'hF, 1'b0, rd, er, lat);
    @(negedge clk);
    mif.req = 1'b1; mif.we = 1'b1; mif.addr = 32'h08; mif.wdata = 32'hCAFE_F00D; mif.be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    mif.req = 1'b0;
    check("mid_in_wait", 32'(mif.ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(mif.ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(mif.done), 32'd0);
    end
    rst_n = 1'b1;
    access(1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, lat);
    check("mid_rst_word_kept", rd, 32'h0000_0007);

    @(negedge clk);
    m0.req = 1'b1; m0.we = 1'b1; m0.addr = 32'h04; m0.wdata = 32'hA5A5_A5A5; m0.be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    m0.req = 1'b0;
    check("w0_wr_done",  32'(m0.done),  32'd1);
    check("w0_wr_ready", 32'(m0.ready), 32'd0);
    check("w0_wr_err",   32'(m0.err),   32'd0);
    @(negedge clk);
    check("w0_ready_back", 32'(m0.ready), 32'd1);
    m0.req = 1'b1; m0.we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m0.req = 1'b0;
    check("w0_rd_done", 32'(m0.done), 32'd1);
    check("w0_rd_data", m0.rdata,     32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
